// File: rtl/gfx_pattern_gen.sv
// Raster-order test pattern source: walks every visible (x,y) of a frame and
// emits {x, y, pixel} on a valid/ready stream, optionally frame after frame.
module gfx_pattern_gen #(
  parameter int H_WIDTH     = 12,
  parameter int V_WIDTH     = 12,
  parameter int COLOR_WIDTH = 4,
  parameter int H_VISIBLE   = 640,
  parameter int V_VISIBLE   = 480
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       start,
  input  logic [1:0]                 pattern,
  input  logic                       continuous,
  output logic                       busy,
  output logic                       frame_done,
  output logic [7:0]                 frame_cnt,
  output logic                       m_gfx_valid,
  input  logic                       m_gfx_ready,
  output logic [H_WIDTH-1:0]         m_gfx_x,
  output logic [V_WIDTH-1:0]         m_gfx_y,
  output logic [3*COLOR_WIDTH-1:0]   m_gfx_pixel
);

  localparam int PIX_W = 3 * COLOR_WIDTH;
  localparam int BAR_W = H_VISIBLE / 8;
  localparam int BC_W  = (BAR_W > 1) ? $clog2(BAR_W) : 1;
  localparam logic [H_WIDTH-1:0] X_LAST  = H_WIDTH'(H_VISIBLE - 1);
  localparam logic [V_WIDTH-1:0] Y_LAST  = V_WIDTH'(V_VISIBLE - 1);
  localparam logic [BC_W-1:0]    BC_LAST = BC_W'(BAR_W - 1);

  typedef enum logic {S_IDLE, S_STREAM} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              pat_q, pat_d;
  logic [BC_W-1:0]         bar_cnt_q, bar_cnt_d;
  logic [2:0]              bar_idx_q, bar_idx_d;
  logic [7:0]              cnt_q, cnt_d, cnt_inc;
  logic [H_WIDTH-1:0]      x_p0, x_d;
  logic [V_WIDTH-1:0]      y_p0, y_d;
  logic [PIX_W-1:0]        pix_p0, pix_d;
  logic                    vld_p0, vld_d;
  logic                    done_p0, done_d;
  logic                    adv, last;

  // Colour for one coordinate; only the coordinate bits each pattern needs are passed in.
  function automatic logic [PIX_W-1:0] pattern_pixel(
    input logic [1:0]             pat,
    input logic [COLOR_WIDTH-1:0] x_lo,
    input logic [COLOR_WIDTH-1:0] y_lo,
    input logic                   chk,
    input logic [2:0]             bar,
    input logic [COLOR_WIDTH-1:0] f
  );
    logic [COLOR_WIDTH-1:0] ones;
    logic [COLOR_WIDTH-1:0] zero;
    ones = '1;
    zero = '0;
    case (pat)
      2'd0:    return {bar[2] ? ones : zero, bar[1] ? ones : zero, bar[0] ? ones : zero};
      2'd1:    return chk ? {ones, ones, ones} : {zero, zero, zero};
      2'd2:    return {x_lo, y_lo, f};
      default: return {f, f, f};
    endcase
  endfunction

  assign adv     = vld_p0 && m_gfx_ready;
  assign last    = (x_p0 == X_LAST) && (y_p0 == Y_LAST);
  assign cnt_inc = cnt_q + 8'd1;

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    bar_cnt_d = bar_cnt_q;
    bar_idx_d = bar_idx_q;
    cnt_d     = cnt_q;
    x_d       = x_p0;
    y_d       = y_p0;
    pix_d     = pix_p0;
    vld_d     = vld_p0;
    done_d    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_STREAM;
          pat_d     = pattern;
          x_d       = '0;
          y_d       = '0;
          bar_cnt_d = '0;
          bar_idx_d = '0;
          vld_d     = 1'b1;
          pix_d     = pattern_pixel(pattern, '0, '0, 1'b0, 3'd0, cnt_q[COLOR_WIDTH-1:0]);
        end
      end
      S_STREAM: begin
        if (adv && last) begin
          done_d = 1'b1;
          cnt_d  = cnt_inc;
          if (continuous) begin
            // Next frame's first beat is presented on the same edge: no bubble.
            pat_d     = pattern;
            x_d       = '0;
            y_d       = '0;
            bar_cnt_d = '0;
            bar_idx_d = '0;
            pix_d     = pattern_pixel(pattern, '0, '0, 1'b0, 3'd0, cnt_inc[COLOR_WIDTH-1:0]);
          end else begin
            state_d = S_IDLE;
            vld_d   = 1'b0;
          end
        end else if (adv) begin
          if (x_p0 == X_LAST) begin
            x_d       = '0;
            y_d       = y_p0 + V_WIDTH'(1);
            bar_cnt_d = '0;
            bar_idx_d = '0;
          end else begin
            x_d = x_p0 + H_WIDTH'(1);
            if (bar_cnt_q == BC_LAST) begin
              bar_cnt_d = '0;
              bar_idx_d = bar_idx_q + 3'd1;
            end else begin
              bar_cnt_d = bar_cnt_q + BC_W'(1);
            end
          end
          pix_d = pattern_pixel(pat_q, x_d[COLOR_WIDTH-1:0], y_d[COLOR_WIDTH-1:0],
                                x_d[4] ^ y_d[4], bar_idx_d, cnt_q[COLOR_WIDTH-1:0]);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Output stage p0: coordinates, pixel and valid leave together.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      bar_cnt_q <= '0;
      bar_idx_q <= '0;
      cnt_q     <= '0;
      x_p0      <= '0;
      y_p0      <= '0;
      pix_p0    <= '0;
      vld_p0    <= 1'b0;
      done_p0   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      bar_cnt_q <= bar_cnt_d;
      bar_idx_q <= bar_idx_d;
      cnt_q     <= cnt_d;
      x_p0      <= x_d;
      y_p0      <= y_d;
      pix_p0    <= pix_d;
      vld_p0    <= vld_d;
      done_p0   <= done_d;
    end
  end

  assign busy        = (state_q == S_STREAM);
  assign frame_done  = done_p0;
  assign frame_cnt   = cnt_q;
  assign m_gfx_valid = vld_p0;
  assign m_gfx_x     = x_p0;
  assign m_gfx_y     = y_p0;
  assign m_gfx_pixel = pix_p0;

endmodule
